// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider family.
package div_pkg;

    localparam int DEF_DIVIDEND_W = 16;
    localparam int DEF_DIVISOR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quotient reported when the divisor is zero.
    localparam logic [DEF_DIVIDEND_W-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
    import div_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] trial;

    // rem_in < divisor keeps shifted < 2*divisor, so the top bit of trial is a true borrow flag.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[DIVISOR_W+1];
        rem_out = q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/seq_div16x8.sv
// Sequential unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_div16x8
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    localparam int                CNT_W    = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]   shift_q, shift_d;
    logic [DIVISOR_W:0]      rem_q, rem_d;
    logic [DIVISOR_W-1:0]    dsr_q, dsr_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    div_zero_q, div_zero_d;

    logic [DIVISOR_W:0]      step_rem;
    logic                    step_q;

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .rem_in  (rem_q),
        .bit_in  (shift_q[DIVIDEND_W-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shift_d    = dividend;
                    dsr_d      = divisor;
                    rem_d      = '0;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                    if (divisor == '0) begin
                        shift_d    = '1;
                        rem_d      = {1'b0, dividend[DIVISOR_W-1:0]};
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            BUSY: begin
                shift_d = {shift_q[DIVIDEND_W-2:0], step_q};
                rem_d   = step_rem;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // out_valid is registered from the DONE state, so it rises one edge after entry.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = shift_q;
    assign remainder = rem_q[DIVISOR_W-1:0];
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_div16x8.sv
// Self-checking bench for seq_div16x8: arithmetic reference model, per-cycle monitor, directed and random ops.
module tb_seq_div16x8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
    } exp_t;

    seq_div16x8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] n, input logic [7:0] d);
        exp_t e;
        e.n = n;
        e.d = d;
        if (d == 8'd0) begin
            e.q   = 16'hFFFF;
            e.r   = n[7:0];
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = 16'(int'(n) / int'(d));
            e.r   = 8'(int'(n) % int'(d));
            e.dz  = 1'b0;
            e.lat = 17;
        end
        return e;
    endfunction

    // Monitor: samples on the falling edge, predicts acceptance for the next rising edge.
    bit          pending = 1'b0;
    int          edges   = 0;
    exp_t        cur;
    logic [15:0] last_q;
    logic [7:0]  last_r;
    logic        last_dz;

    always @(negedge clk) begin
        if (rst) begin
            pending = 1'b0;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
        end else if (pending) begin
            edges++;
            check("busy_in_ready", 32'(in_ready), 32'd0);
            if (edges < cur.lat) begin
                check("early_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("out_valid", 32'(out_valid), 32'd1);
                check("quotient", 32'(quotient), 32'(cur.q));
                check("remainder", 32'(remainder), 32'(cur.r));
                check("div_zero", 32'(div_zero), 32'(cur.dz));
                if (edges == cur.lat && cur.d != 8'd0) begin
                    check("identity_qd_r", 32'(quotient) * 32'(cur.d) + 32'(remainder), 32'(cur.n));
                    check("rem_lt_div", 32'(remainder < cur.d), 32'd1);
                end
                last_q  = quotient;
                last_r  = remainder;
                last_dz = div_zero;
                if (out_ready) pending = 1'b0;
            end
        end else begin
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_in_ready", 32'(in_ready), 32'd1);
            if (in_valid) begin
                cur     = model(dividend, divisor);
                pending = 1'b1;
                edges   = -1;
            end
        end
    end

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] n, input logic [7:0] d, input int hold,
                          input bit lit, input logic [15:0] lq, input logic [7:0] lr, input logic ldz);
        bit got = 1'b0;
        dividend = n;
        divisor  = d;
        in_valid = 1'b1;
        wait_accept();
        // Junk on the input side while busy must be ignored.
        in_valid  = 1'($urandom_range(0, 1));
        dividend  = 16'($urandom);
        divisor   = 8'($urandom);
        out_ready = (hold == 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("out_valid_timeout", 32'(got), 32'd1);
        in_valid = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (lit) begin
            check("lit_quotient", 32'(last_q), 32'(lq));
            check("lit_remainder", 32'(last_r), 32'(lr));
            check("lit_div_zero", 32'(last_dz), 32'(ldz));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(16'd100,    8'd7,   0, 1'b1, 16'd14,    8'd2,   1'b0);
        run_op(16'd65535,  8'd255, 1, 1'b1, 16'd257,   8'd0,   1'b0);
        run_op(16'd65535,  8'd1,   0, 1'b1, 16'd65535, 8'd0,   1'b0);
        run_op(16'd3,      8'd200, 2, 1'b1, 16'd0,     8'd3,   1'b0);
        run_op(16'h1234,   8'd0,   0, 1'b1, 16'hFFFF,  8'h34,  1'b1);
        run_op(16'd10,     8'd3,   0, 1'b1, 16'd3,     8'd1,   1'b0);
        run_op(16'd5000,   8'd13,  20, 1'b1, 16'd384,  8'd8,   1'b0);

        // Abort mid-operation with an asynchronous reset.
        dividend = 16'd1000;
        divisor  = 8'd9;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_quotient", 32'(quotient), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(16'd1000, 8'd9, 1, 1'b1, 16'd111, 8'd1, 1'b0);

        for (int k = 0; k < 2500; k++) begin
            logic [15:0] rn;
            logic [7:0]  rd;
            rn = 16'($urandom);
            rd = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            run_op(rn, rd, $urandom_range(0, 2), 1'b0, 16'd0, 8'd0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
